i2c_byte_master: RTL and testbench

- Register-mapped single-byte I2C master on the Memory_Bus slave side of the APB slave: the APB slave drives ce/wren/rden/addr/wdata and waits on ready.
- Software loads a 7-bit target address and a TX byte, then writes CTRL.start.
- Block runs START, address+R/W, ACK, one data byte, ACK/NACK, STOP on open-drain SCL/SDA, then reports status.

---
 rtl/i2c_byte_master_if.sv | 27 ++
 rtl/i2c_byte_master.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_byte_master_if.sv
// Register-bus and open-drain I2C pin bundle for i2c_byte_master.
// The slave modport is the block's view. The master modport is the view of the
// APB bridge and pad model that drive it.
interface i2c_byte_master_if #(
    parameter int DATA_W = 8
);
    logic              ce;
    logic              wren;
    logic              rden;
    logic [1:0]        addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              scl_oe;
    logic              sda_oe;
    logic              sda_i;

    modport slave (
        input  ce, wren, rden, addr, wdata, sda_i,
        output rdata, ready, scl_oe, sda_oe
    );

    modport master (
        output ce, wren, rden, addr, wdata, sda_i,
        input  rdata, ready, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_byte_master.sv
// Single-byte I2C master behind a small register map.
// Software loads SADDR and TXDATA, then writes CTRL.start. The block then runs
// START, address+R/W, ACK, one data byte, ACK/NACK and STOP, and reports the
// result in CTRL.
// The SCL and SDA enables are decoded directly from registered state. An
// asynchronous reset therefore releases both lines immediately.
module i2c_byte_master #(
    parameter int CLK_DIV = 50,
    parameter int DATA_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    i2c_byte_master_if.slave bus
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] QMAX = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DACK,
        S_STOP
    } state_t;

    state_t      r_state;
    logic [1:0]  r_q;        // quarter index inside the current phase
    logic [2:0]  r_bit;      // bit index, MSB first
    logic [CW-1:0] r_qcnt;   // clk count within a quarter

    logic [6:0]  r_saddr;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic        r_rw;
    logic        r_done;
    logic        r_ackerr;
    logic        r_samp;     // sda_i captured at q2 of an ACK slot
    logic        r_ready;
    logic [DATA_W-1:0] r_rdata;

    state_t      w_state_nxt;
    logic [1:0]  w_q_nxt;
    logic [2:0]  w_bit_nxt;
    logic        w_scl_oe;
    logic        w_sda_oe;
    logic        w_samp_en;
    logic        w_rx_shift;
    logic        w_set_done;
    logic        w_set_ackerr;

    logic        w_req;
    logic        w_wr;
    logic        w_rd;
    logic        w_busy;
    logic        w_start;
    logic        w_tick;
    logic [7:0]  w_addr_byte;
    logic [7:0]  w_rd_byte;

    // A request in the ready cycle is not accepted. This keeps a held request
    // from being serviced twice. When wren and rden are both high, the access
    // is a write.
    assign w_req       = bus.ce & (bus.wren | bus.rden) & ~r_ready;
    assign w_wr        = w_req & bus.wren;
    assign w_rd        = w_req & ~bus.wren;
    assign w_busy      = (r_state != S_IDLE);
    assign w_start     = w_wr & (bus.addr == 2'd0) & bus.wdata[0] & ~w_busy;
    assign w_tick      = w_busy & (r_qcnt == QMAX);
    assign w_addr_byte = {r_saddr, r_rw};

    assign bus.ready  = r_ready;
    assign bus.rdata  = r_rdata;
    assign bus.scl_oe = w_scl_oe;
    assign bus.sda_oe = w_sda_oe;

    // Quarter-period divider: parked at zero while idle, so the first tick
    // comes exactly CLK_DIV cycles after START begins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_qcnt <= '0;
        end else if (!w_busy || r_qcnt == QMAX) begin
            r_qcnt <= '0;
        end else begin
            r_qcnt <= r_qcnt + CW'(1);
        end
    end

    // FSM state, quarter index and bit index registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_q     <= 2'd0;
            r_bit   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    // Next-state logic and line drive. In a bit slot, SCL is held low in q0
    // and q3 and released in q1 and q2. SDA changes only at a q0 boundary.
    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_bit_nxt    = r_bit;
        w_scl_oe     = 1'b0;
        w_sda_oe     = 1'b0;
        w_samp_en    = 1'b0;
        w_rx_shift   = 1'b0;
        w_set_done   = 1'b0;
        w_set_ackerr = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_START;
                    w_q_nxt     = 2'd0;
                end
            end

            S_START: begin
                w_sda_oe = 1'b1;
                w_scl_oe = (r_q == 2'd1);
                if (w_tick) begin
                    if (r_q == 2'd0) begin
                        w_q_nxt = 2'd1;
                    end else begin
                        w_state_nxt = S_ADDR;
                        w_q_nxt     = 2'd0;
                        w_bit_nxt   = 3'd7;
                    end
                end
            end

            S_ADDR: begin
                w_scl_oe = (r_q == 2'd0) || (r_q == 2'd3);
                w_sda_oe = ~w_addr_byte[r_bit];
                if (w_tick) begin
                    if (r_q != 2'd3) begin
                        w_q_nxt = r_q + 2'd1;
                    end else begin
                        w_q_nxt = 2'd0;
                        if (r_bit == 3'd0) begin
                            w_state_nxt = S_ADDR_ACK;
                        end else begin
                            w_bit_nxt = r_bit - 3'd1;
                        end
                    end
                end
            end

            S_ADDR_ACK: begin
                w_scl_oe  = (r_q == 2'd0) || (r_q == 2'd3);
                w_samp_en = w_tick & (r_q == 2'd2);
                if (w_tick) begin
                    if (r_q != 2'd3) begin
                        w_q_nxt = r_q + 2'd1;
                    end else begin
                        w_q_nxt = 2'd0;
                        if (r_samp) begin
                            w_set_ackerr = 1'b1;
                            w_state_nxt  = S_STOP;
                        end else begin
                            w_state_nxt = S_DATA;
                            w_bit_nxt   = 3'd7;
                        end
                    end
                end
            end

            S_DATA: begin
                w_scl_oe   = (r_q == 2'd0) || (r_q == 2'd3);
                w_sda_oe   = ~r_rw & ~r_tx[r_bit];
                w_rx_shift = r_rw & w_tick & (r_q == 2'd2);
                if (w_tick) begin
                    if (r_q != 2'd3) begin
                        w_q_nxt = r_q + 2'd1;
                    end else begin
                        w_q_nxt = 2'd0;
                        if (r_bit == 3'd0) begin
                            w_state_nxt = S_DACK;
                        end else begin
                            w_bit_nxt = r_bit - 3'd1;
                        end
                    end
                end
            end

            S_DACK: begin
                // On a read, SDA stays released here. That is the master NACK
                // that ends the transfer after one byte.
                w_scl_oe  = (r_q == 2'd0) || (r_q == 2'd3);
                w_samp_en = ~r_rw & w_tick & (r_q == 2'd2);
                if (w_tick) begin
                    if (r_q != 2'd3) begin
                        w_q_nxt = r_q + 2'd1;
                    end else begin
                        w_q_nxt      = 2'd0;
                        w_set_ackerr = ~r_rw & r_samp;
                        w_state_nxt  = S_STOP;
                    end
                end
            end

            S_STOP: begin
                w_scl_oe = (r_q == 2'd0);
                w_sda_oe = (r_q != 2'd2);
                if (w_tick) begin
                    if (r_q == 2'd2) begin
                        w_q_nxt     = 2'd0;
                        w_set_done  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_q_nxt = r_q + 2'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_q_nxt     = 2'd0;
            end
        endcase
    end

    // Read-data mux for the register map. Bits above [7:0] read as zero.
    always_comb begin
        w_rd_byte = 8'h00;
        case (bus.addr)
            2'd0: w_rd_byte = {5'b0, r_done, r_ackerr, w_busy};
            2'd1: w_rd_byte = {1'b0, r_saddr};
            2'd2: w_rd_byte = r_tx;
            2'd3: w_rd_byte = r_rx;
            default: w_rd_byte = 8'h00;
        endcase
    end

    // Register file, one-cycle bus handshake, status flags and data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_saddr  <= 7'd0;
            r_tx     <= 8'd0;
            r_rx     <= 8'd0;
            r_rw     <= 1'b0;
            r_done   <= 1'b0;
            r_ackerr <= 1'b0;
            r_samp   <= 1'b0;
        end else begin
            r_ready <= w_req;
            r_rdata <= w_rd ? DATA_W'(w_rd_byte) : '0;

            // Configuration registers are frozen while a transfer runs.
            if (w_wr && !w_busy) begin
                case (bus.addr)
                    2'd0: if (bus.wdata[0]) r_rw <= bus.wdata[1];
                    2'd1: r_saddr <= bus.wdata[6:0];
                    2'd2: r_tx    <= bus.wdata[7:0];
                    default: ;
                endcase
            end

            // Setting done takes priority over a CTRL read in the same cycle.
            // This keeps a completion from being lost.
            if (w_start) begin
                r_done   <= 1'b0;
                r_ackerr <= 1'b0;
            end else begin
                if (w_set_ackerr) r_ackerr <= 1'b1;
                if (w_set_done) begin
                    r_done <= 1'b1;
                end else if (w_rd && bus.addr == 2'd0) begin
                    r_done <= 1'b0;
                end
            end

            if (w_samp_en)  r_samp <= bus.sda_i;
            if (w_rx_shift) r_rx   <= {r_rx[6:0], bus.sda_i};
        end
    end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: register accesses plus randomized transfers.
// An I2C target model decodes the open-drain lines into bytes and ACK bits.
module tb_i2c_byte_master;

    localparam int CLK_DIV = 4;
    localparam int DATA_W  = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    i2c_byte_master_if #(.DATA_W(DATA_W)) bus_if ();

    i2c_byte_master #(
        .CLK_DIV(CLK_DIV),
        .DATA_W (DATA_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Target model controls (set by the stimulus)
    logic       ack_addr = 1'b1;
    logic       ack_data = 1'b1;
    logic [7:0] rd_byte  = 8'h00;

    // Target model state (written only by the monitor)
    logic       pull = 1'b0;
    logic       p_scl = 1'b1, p_sda = 1'b1, m_scl, m_sda;
    logic       rd_mode = 1'b0, addr_acked = 1'b0;
    logic [7:0] shreg = 8'h00;
    int         bitn = 0, byten = 0, hcnt = 0, hi_bad = 0;
    int         starts = 0, stops = 0, nb = 0;
    logic [7:0] mon_byte [0:63];
    logic       mon_ack  [0:63];

    assign bus_if.sda_i = ~bus_if.sda_oe & ~pull;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Open-drain line decoder and I2C target
    always @(negedge clk) begin
        m_scl = ~bus_if.scl_oe;
        m_sda = bus_if.sda_i;
        if (p_scl && m_scl) hcnt++;
        if (!p_scl && m_scl) hcnt = 1;
        if (!reset) begin
            pull = 1'b0; bitn = 0; byten = 0;
        end else if (p_scl && m_scl && p_sda && !m_sda) begin
            starts++; bitn = 0; byten = 0; pull = 1'b0; addr_acked = 1'b0;
        end else if (p_scl && m_scl && !p_sda && m_sda) begin
            stops++; bitn = 0; pull = 1'b0;
        end else if (!p_scl && m_scl) begin
            if (bitn < 8) begin
                shreg = {shreg[6:0], m_sda};
                bitn++;
            end else begin
                mon_byte[nb % 64] = shreg;
                mon_ack[nb % 64]  = m_sda;
                nb++;
                if (byten == 0) begin
                    rd_mode    = shreg[0];
                    addr_acked = !m_sda;
                end
                byten++;
                bitn = 0;
            end
        end else if (p_scl && !m_scl) begin
            if ((bitn > 0 || byten > 0) && hcnt != 2 * CLK_DIV) hi_bad++;
            if (bitn == 8) begin
                if (byten == 0)                  pull = ack_addr;
                else if (byten == 1 && !rd_mode) pull = ack_data;
                else                             pull = 1'b0;
            end else if (byten == 1 && rd_mode && addr_acked) begin
                pull = ~rd_byte[7 - bitn];
            end else begin
                pull = 1'b0;
            end
        end
        p_scl = m_scl;
        p_sda = m_sda;
    end

    // One register access; entered and left at 1 time unit after a posedge
    task automatic bus_access(input logic we, input logic re, input logic [1:0] a,
                              input logic [7:0] d, output logic [7:0] rd);
        int lat;
        bus_if.ce = 1'b1; bus_if.wren = we; bus_if.rden = re;
        bus_if.addr = a; bus_if.wdata = d;
        lat = 0;
        rd  = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (bus_if.ready) begin
                lat = i;
                break;
            end
        end
        rd = bus_if.rdata;
        check("ready_latency", lat, 1);
        bus_if.ce = 1'b0; bus_if.wren = 1'b0; bus_if.rden = 1'b0;
        @(posedge clk); #1;
        check("ready_single", bus_if.ready, 1'b0);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        bus_access(1'b1, 1'b0, a, d, dummy);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] rd);
        bus_access(1'b0, 1'b1, a, 8'h00, rd);
    endtask

    // Full transfer compared against what the I2C rules imply for the inputs
    task automatic run_txn(input logic [6:0] sa, input logic [7:0] tx, input logic rw,
                           input logic aa, input logic ad, input logic [7:0] rb,
                           input logic poke);
        int base_nb, base_st, base_sp, base_hb, exp_n;
        logic exp_err, fin;
        logic [7:0] v;
        ack_addr = aa; ack_data = ad; rd_byte = rb;
        base_nb = nb; base_st = starts; base_sp = stops; base_hb = hi_bad;
        exp_err = !aa || (!rw && !ad);
        exp_n   = aa ? 2 : 1;

        bus_write(2'd1, {1'b0, sa});
        bus_write(2'd2, tx);
        bus_write(2'd0, {6'b0, rw, 1'b1});
        if (poke) begin
            bus_write(2'd2, 8'hFF);
            bus_write(2'd1, 8'h11);
        end
        fin = 1'b0;
        v = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            bus_read(2'd0, v);
            if (!v[0]) begin
                fin = 1'b1;
                break;
            end
        end
        check("txn_finished", fin, 1'b1);
        check("ctrl_final", v, {5'b0, 1'b1, exp_err, 1'b0});
        check("byte_count", nb - base_nb, exp_n);
        check("addr_byte", mon_byte[base_nb % 64], {sa, rw});
        check("addr_ack_bit", mon_ack[base_nb % 64], !aa);
        if (aa) begin
            check("data_byte", mon_byte[(base_nb + 1) % 64], rw ? rb : tx);
            check("data_ack_bit", mon_ack[(base_nb + 1) % 64], rw ? 1'b1 : !ad);
        end
        check("start_count", starts - base_st, 1);
        check("stop_count", stops - base_sp, 1);
        check("scl_high_time", hi_bad - base_hb, 0);
        if (rw && aa) begin
            bus_read(2'd3, v);
            check("rxdata", v, rb);
        end
        bus_read(2'd0, v);
        check("ctrl_done_cleared", v, {5'b0, 1'b0, exp_err, 1'b0});
        if (poke) begin
            bus_read(2'd2, v);
            check("txdata_protected", v, tx);
            bus_read(2'd1, v);
            check("saddr_protected", v, {1'b0, sa});
        end
    endtask

    initial begin
        logic [7:0] v;
        logic hit;
        bus_if.ce = 1'b0; bus_if.wren = 1'b0; bus_if.rden = 1'b0;
        bus_if.addr = 2'd0; bus_if.wdata = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus_if.ready, 1'b0);
        check("rst_rdata", bus_if.rdata, 8'h00);
        check("rst_scl_oe", bus_if.scl_oe, 1'b0);
        check("rst_sda_oe", bus_if.sda_oe, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), v);
            check("reg_after_reset", v, 8'h00);
        end

        // Register access: write SADDR, then a held read shows exactly one ready
        bus_write(2'd1, 8'h50);
        bus_if.ce = 1'b1; bus_if.rden = 1'b1; bus_if.addr = 2'd1;
        @(posedge clk); #1;
        check("held_rd_ready", bus_if.ready, 1'b1);
        check("held_rd_data", bus_if.rdata, 8'h50);
        @(posedge clk); #1;
        check("held_rd_no_repeat", bus_if.ready, 1'b0);
        bus_if.ce = 1'b0; bus_if.rden = 1'b0;
        @(posedge clk); #1;

        // wren and rden together act as a write; RXDATA ignores writes
        bus_access(1'b1, 1'b1, 2'd2, 8'h5A, v);
        bus_read(2'd2, v);
        check("both_is_write", v, 8'h5A);
        bus_write(2'd3, 8'h77);
        bus_read(2'd3, v);
        check("rxdata_ro", v, 8'h00);

        // Directed transfers
        run_txn(7'h50, 8'hA5, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        run_txn(7'h50, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0);
        run_txn(7'h50, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        run_txn(7'h50, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        run_txn(7'h2B, 8'h96, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);

        // Randomized transfers
        for (int t = 0; t < 12; t++) begin
            run_txn(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)));
        end

        // Reset in the middle of the address byte
        ack_addr = 1'b1; ack_data = 1'b1;
        bus_write(2'd1, 8'h50);
        bus_write(2'd0, 8'h01);
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (byten == 0 && bitn >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_addr", hit, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("midrst_scl_oe", bus_if.scl_oe, 1'b0);
        check("midrst_sda_oe", bus_if.sda_oe, 1'b0);
        check("midrst_ready", bus_if.ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        bus_read(2'd0, v);
        check("midrst_ctrl", v, 8'h00);
        bus_read(2'd3, v);
        check("midrst_rxdata", v, 8'h00);
        run_txn(7'h50, 8'hC3, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
